// File: rtl/pipe_stage_fifo.sv
// Purpose : small inter-stage FIFO between pipeline stages, with a synchronous flush for branch cancel.
// Latency : 1 cycle from push to out_valid; out_bus is read combinationally from the head entry, with no bypass.
// Backpr. : in_allow_in drops when full (FULL_POP=1: it stays high when downstream pops this cycle); out_allow_in stalls the head entry.
//
// Ports:
//   clk, resetn                   single clock, asynchronous active-low reset
//   in_valid/in_bus/in_allow_in   upstream handshake and payload
//   out_valid/out_bus/out_allow_in downstream handshake and payload (oldest entry)
//   flush                         discards all entries at the next edge
//   count                         occupied entry count, 0..DEPTH
module pipe_stage_fifo #(
    parameter int BUS_WD   = 64,
    parameter int DEPTH    = 4,
    parameter bit FULL_POP = 1'b0
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      in_valid,
    input  logic [BUS_WD-1:0]         in_bus,
    output logic                      in_allow_in,
    output logic                      out_valid,
    output logic [BUS_WD-1:0]         out_bus,
    input  logic                      out_allow_in,
    input  logic                      flush,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("pipe_stage_fifo: DEPTH must be a power of two >= 2");
        end
    endgenerate

    logic [BUS_WD-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              is_full;
    logic              push;
    logic              pop;

    assign is_full   = (count == FULL_CNT);
    // Flush hides the head so downstream never consumes an entry being cancelled.
    assign out_valid = (count != '0) & ~flush;
    assign out_bus   = mem[rd_ptr];

    // With FULL_POP the slot freed by this cycle's pop is reused immediately.
    assign in_allow_in = FULL_POP ? (~is_full | out_allow_in) : ~is_full;

    assign push = in_valid & in_allow_in & ~flush;
    assign pop  = out_valid & out_allow_in;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_bus;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// Purpose : directed bench for pipe_stage_fifo; two instances (FULL_POP=0 and 1) share stimulus.
// Latency : expected payloads are queued at issue and checked by a negedge monitor on each pop.
// Backpr. : out_allow_in is driven by the stimulus; the monitor only checks cycles where a pop occurs.
module tb_pipe_stage_fifo;

    logic        clk;
    logic        resetn;
    logic        in_valid;
    logic [63:0] in_bus;
    logic        out_allow_in;
    logic        flush;

    logic        in_allow_in0, out_valid0, in_allow_in1, out_valid1;
    logic [63:0] out_bus0, out_bus1;
    logic [2:0]  count0, count1;

    int total = 0;
    int bad   = 0;

    logic [63:0] q0[$];
    logic [63:0] q1[$];

    pipe_stage_fifo #(.BUS_WD(64), .DEPTH(4), .FULL_POP(1'b0)) u_fifo0 (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_bus(in_bus),
        .in_allow_in(in_allow_in0), .out_valid(out_valid0), .out_bus(out_bus0),
        .out_allow_in(out_allow_in), .flush(flush), .count(count0)
    );

    pipe_stage_fifo #(.BUS_WD(64), .DEPTH(4), .FULL_POP(1'b1)) u_fifo1 (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_bus(in_bus),
        .in_allow_in(in_allow_in1), .out_valid(out_valid1), .out_bus(out_bus1),
        .out_allow_in(out_allow_in), .flush(flush), .count(count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Move to 1ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after driving inputs.
    task automatic settle();
        #1;
    endtask

    // Scoreboard monitor: every pop must match the head of the expected queue.
    always @(negedge clk) begin
        if (resetn) begin
            if (out_valid0 && out_allow_in) begin
                if (q0.size() == 0) begin
                    total++; bad++;
                    $display("FAIL pop0_unexpected: got %0h expected none", out_bus0);
                end else begin
                    chk("pop0_data", out_bus0, q0.pop_front());
                end
            end
            if (out_valid1 && out_allow_in) begin
                if (q1.size() == 0) begin
                    total++; bad++;
                    $display("FAIL pop1_unexpected: got %0h expected none", out_bus1);
                end else begin
                    chk("pop1_data", out_bus1, q1.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] fill_v [4];
        logic [63:0] full_v [4];
        fill_v = '{64'h11, 64'h22, 64'h33, 64'h44};
        full_v = '{64'hA, 64'hB, 64'hC, 64'hD};

        resetn = 1'b0; in_valid = 1'b0; in_bus = '0; out_allow_in = 1'b0; flush = 1'b0;
        #2;
        // Reset state
        chk("rst_count0", 64'(count0), 64'd0);
        chk("rst_count1", 64'(count1), 64'd0);
        chk("rst_ovalid0", 64'(out_valid0), 64'd0);
        chk("rst_ovalid1", 64'(out_valid1), 64'd0);
        chk("rst_allow0", 64'(in_allow_in0), 64'd1);
        chk("rst_allow1", 64'(in_allow_in1), 64'd1);
        #10;
        resetn = 1'b1;

        // Fill then drain
        out_allow_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_bus = fill_v[i];
            q0.push_back(fill_v[i]); q1.push_back(fill_v[i]);
            tick();
        end
        // Refused payload while full must not disturb stored data.
        in_valid = 1'b1; in_bus = 64'hDEAD;
        settle();
        chk("full_count0", 64'(count0), 64'd4);
        chk("full_count1", 64'(count1), 64'd4);
        chk("full_allow0", 64'(in_allow_in0), 64'd0);
        chk("full_allow1", 64'(in_allow_in1), 64'd0);
        tick();
        in_valid = 1'b0;
        out_allow_in = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        settle();
        chk("drain_count0", 64'(count0), 64'd0);
        chk("drain_ovalid0", 64'(out_valid0), 64'd0);
        chk("drain_count1", 64'(count1), 64'd0);

        // Streaming through both pointer wraps
        out_allow_in = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            in_valid = 1'b1; in_bus = 64'(i);
            q0.push_back(64'(i)); q1.push_back(64'(i));
            settle();
            if (i == 1) begin
                chk("stream_first_ovalid", 64'(out_valid0), 64'd0);
            end else begin
                chk("stream_ovalid", 64'(out_valid0), 64'd1);
                chk("stream_count", 64'(count0), 64'd1);
            end
            tick();
        end
        in_valid = 1'b0;
        tick();
        settle();
        chk("stream_end_count0", 64'(count0), 64'd0);
        chk("stream_end_count1", 64'(count1), 64'd0);

        // Full with simultaneous push and pop
        out_allow_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_bus = full_v[i];
            q0.push_back(full_v[i]); q1.push_back(full_v[i]);
            tick();
        end
        in_valid = 1'b1; in_bus = 64'hE; out_allow_in = 1'b1;
        q1.push_back(64'hE);
        settle();
        chk("fp_allow0", 64'(in_allow_in0), 64'd0);
        chk("fp_allow1", 64'(in_allow_in1), 64'd1);
        tick();
        in_valid = 1'b0; out_allow_in = 1'b0;
        settle();
        chk("fp_count0", 64'(count0), 64'd3);
        chk("fp_count1", 64'(count1), 64'd4);
        out_allow_in = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        settle();
        chk("fp_drain_count0", 64'(count0), 64'd0);
        chk("fp_drain_count1", 64'(count1), 64'd0);

        // Flush discards stored entries and a concurrent push
        out_allow_in = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1; in_bus = 64'(i + 32'h40);
            tick();
        end
        in_valid = 1'b1; in_bus = 64'h99; flush = 1'b1;
        settle();
        chk("flush_count", 64'(count0), 64'd3);
        chk("flush_ovalid0", 64'(out_valid0), 64'd0);
        chk("flush_ovalid1", 64'(out_valid1), 64'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        settle();
        chk("post_flush_count0", 64'(count0), 64'd0);
        chk("post_flush_count1", 64'(count1), 64'd0);
        in_valid = 1'b1; in_bus = 64'h55;
        q0.push_back(64'h55); q1.push_back(64'h55);
        tick();
        in_valid = 1'b0; out_allow_in = 1'b1;
        settle();
        chk("post_flush_ovalid", 64'(out_valid0), 64'd1);
        tick();
        settle();
        chk("post_flush_empty", 64'(count0), 64'd0);

        // Asynchronous reset mid-cycle
        out_allow_in = 1'b0;
        in_valid = 1'b1; in_bus = 64'h66; tick();
        in_bus = 64'h77; tick();
        in_valid = 1'b0;
        settle();
        chk("pre_arst_count", 64'(count0), 64'd2);
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_count0", 64'(count0), 64'd0);
        chk("arst_count1", 64'(count1), 64'd0);
        chk("arst_ovalid0", 64'(out_valid0), 64'd0);
        chk("arst_allow0", 64'(in_allow_in0), 64'd1);
        chk("arst_allow1", 64'(in_allow_in1), 64'd1);
        #1;
        resetn = 1'b1;
        in_valid = 1'b1; in_bus = 64'h88;
        q0.push_back(64'h88); q1.push_back(64'h88);
        tick();
        in_valid = 1'b0;
        settle();
        chk("first_push_count", 64'(count0), 64'd1);
        out_allow_in = 1'b1;
        tick();
        settle();
        chk("final_count0", 64'(count0), 64'd0);
        chk("final_count1", 64'(count1), 64'd0);

        chk("q0_empty", 64'(q0.size()), 64'd0);
        chk("q1_empty", 64'(q1.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
